// File: rtl/dot_product_accumulator_if.sv
// Term/result handshake bundle between the multiplier
// side, the accumulator and the result consumer.
interface dot_product_accumulator_if #(
  parameter int ACC_W = 10
);
  logic             op_valid;
  logic             op_ready;
  logic [5:0]       P;
  logic             clear;
  logic [ACC_W-1:0] sum;
  logic             sum_valid;
  logic             sum_ready;
  logic [3:0]       term_cnt;
  logic             overflow;

  modport master (
    output op_valid, P, clear, sum_ready,
    input  op_ready, sum, sum_valid,
    input  term_cnt, overflow
  );

  modport slave (
    input  op_valid, P, clear, sum_ready,
    output op_ready, sum, sum_valid,
    output term_cnt, overflow
  );
endinterface

// File: rtl/dot_product_accumulator.sv
// Accumulates multiplier products into a dot product,
// tracking term validity alongside the multiplier latency.
module dot_product_accumulator #(
  parameter int N_TERMS  = 4,
  parameter int MULT_LAT = 2,
  parameter int ACC_W    = 10
) (
  input  logic CLK1,
  input  logic RST1,
  dot_product_accumulator_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, ISSUE, DRAIN, DONE
  } state_e;

  localparam logic [3:0] N_LAST = 4'(N_TERMS);

  state_e              state_q, state_d;
  logic [MULT_LAT-1:0] pipe_q, pipe_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [3:0]          issued_q, issued_d;
  logic [3:0]          term_cnt_q, term_cnt_d;
  logic                ovf_q, ovf_d;
  logic                live_q, live_d;

  logic             op_ready;
  logic             sum_valid;
  logic             accept;
  logic             add;
  logic             last_issue;
  logic             last_add;
  logic             carry;
  logic [ACC_W-1:0] acc_sum;

  // clear wins over both a new term and a landing product
  always_comb begin
    accept     = bus.op_valid & op_ready & ~bus.clear;
    add        = pipe_q[MULT_LAT-1]
               & (state_q != DONE)
               & ~bus.clear;
    last_issue = accept
               & ((issued_q + 4'd1) == N_LAST);
    last_add   = add
               & ((term_cnt_q + 4'd1) == N_LAST);
    {carry, acc_sum} = {1'b0, acc_q}
                     + {{(ACC_W-5){1'b0}}, bus.P};
  end

  always_ff @(posedge CLK1 or posedge RST1) begin
    if (RST1) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ISSUE: begin
        if (accept)
          state_d = last_issue ? DRAIN : ISSUE;
      end
      DRAIN: begin
        if (last_add) state_d = DONE;
      end
      DONE: begin
        if (bus.sum_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.clear) state_d = IDLE;
  end

  // live_q keeps op_ready low until the first edge after reset
  always_comb begin
    op_ready  = live_q
              & ((state_q == IDLE) | (state_q == ISSUE));
    sum_valid = (state_q == DONE);
  end

  always_comb begin
    pipe_d     = MULT_LAT'({pipe_q, accept});
    acc_d      = acc_q;
    issued_d   = issued_q;
    term_cnt_d = term_cnt_q;
    ovf_d      = ovf_q;
    live_d     = 1'b1;
    if (accept) issued_d = issued_q + 4'd1;
    if (add) begin
      acc_d      = acc_sum;
      term_cnt_d = term_cnt_q + 4'd1;
      ovf_d      = ovf_q | carry;
    end
    if (bus.clear || (sum_valid && bus.sum_ready)) begin
      acc_d      = '0;
      issued_d   = '0;
      term_cnt_d = '0;
      ovf_d      = 1'b0;
    end
    if (bus.clear) pipe_d = '0;
  end

  always_ff @(posedge CLK1 or posedge RST1) begin
    if (RST1) begin
      pipe_q     <= '0;
      acc_q      <= '0;
      issued_q   <= '0;
      term_cnt_q <= '0;
      ovf_q      <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      pipe_q     <= pipe_d;
      acc_q      <= acc_d;
      issued_q   <= issued_d;
      term_cnt_q <= term_cnt_d;
      ovf_q      <= ovf_d;
      live_q     <= live_d;
    end
  end

  assign bus.op_ready  = op_ready;
  assign bus.sum       = acc_q;
  assign bus.sum_valid = sum_valid;
  assign bus.term_cnt  = term_cnt_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed and randomized checks of the dot-product
// accumulator behind a modelled 2-cycle multiplier.
module tb_dot_product_accumulator;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dot_product_accumulator_if #(.ACC_W(10)) dif ();
  dot_product_accumulator_if #(.ACC_W(6))  oif ();

  dot_product_accumulator #(
    .N_TERMS(4), .MULT_LAT(LAT), .ACC_W(10)
  ) u_dut (
    .CLK1(clk), .RST1(rst), .bus(dif)
  );

  dot_product_accumulator #(
    .N_TERMS(2), .MULT_LAT(LAT), .ACC_W(6)
  ) u_ovf (
    .CLK1(clk), .RST1(rst), .bus(oif)
  );

  // upstream multiplier: registers A*B, product after LAT cycles
  logic [2:0] a0, b0, a1, b1;
  logic [5:0] p0_s1, p0_s2, p1_s1, p1_s2;
  always @(posedge clk) begin
    p0_s1 <= 6'(a0) * 6'(b0);
    p0_s2 <= p0_s1;
    p1_s1 <= 6'(a1) * 6'(b1);
    p1_s2 <= p1_s1;
  end
  assign dif.P = p0_s2;
  assign oif.P = p1_s2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_acc = 0;
  int exp_total = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue_term(input logic [2:0] a,
                            input logic [2:0] b);
    bit done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      dif.op_valid = 1'b1;
      a0 = a;
      b0 = b;
      if (dif.op_ready === 1'b1) begin
        exp_total += int'(a) * int'(b);
        last_acc = cyc;
        done = 1'b1;
      end
      tick();
    end
    dif.op_valid = 1'b0;
    chk("term_accepted", 32'(done), 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      dif.op_valid = 1'b0;
      a0 = 3'($urandom_range(0, 7));
      b0 = 3'($urandom_range(0, 7));
      tick();
    end
  endtask

  task automatic wait_result();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (dif.sum_valid === 1'b1) seen = 1'b1;
      else tick();
    end
    chk("sum_valid_seen", 32'(seen), 1);
    chk("result_sum", 32'(dif.sum), exp_total % 1024);
    chk("result_cnt", 32'(dif.term_cnt), 4);
    chk("result_ovf", 32'(dif.overflow),
        32'(exp_total >= 1024));
    chk("result_latency", cyc - last_acc, LAT + 1);
  endtask

  task automatic handoff(input int stall);
    dif.sum_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("hold_valid", 32'(dif.sum_valid), 1);
      chk("hold_sum", 32'(dif.sum), exp_total % 1024);
      chk("hold_ready", 32'(dif.op_ready), 0);
    end
    dif.sum_ready = 1'b1;
    tick();
    dif.sum_ready = 1'b0;
    chk("post_valid", 32'(dif.sum_valid), 0);
    chk("post_ready", 32'(dif.op_ready), 1);
    chk("post_sum", 32'(dif.sum), 0);
    chk("post_cnt", 32'(dif.term_cnt), 0);
    exp_total = 0;
  endtask

  task automatic random_dot();
    for (int k = 0; k < 4; k++) begin
      issue_term(3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)));
      idle_cycles(int'($urandom_range(0, 2)));
    end
    wait_result();
    handoff(int'($urandom_range(0, 3)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    dif.op_valid  = 1'b0;
    dif.clear     = 1'b0;
    dif.sum_ready = 1'b0;
    oif.op_valid  = 1'b0;
    oif.clear     = 1'b0;
    oif.sum_ready = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1;

    chk("rst_ready", 32'(dif.op_ready), 0);
    chk("rst_sum", 32'(dif.sum), 0);
    chk("rst_valid", 32'(dif.sum_valid), 0);
    chk("rst_cnt", 32'(dif.term_cnt), 0);
    chk("rst_ovf", 32'(dif.overflow), 0);
    rst = 1'b0;
    tick();
    chk("rel_ready", 32'(dif.op_ready), 1);

    // back-to-back terms: 15+49+12+0
    issue_term(3'd3, 3'd5);
    issue_term(3'd7, 3'd7);
    issue_term(3'd2, 3'd6);
    issue_term(3'd0, 3'd4);
    for (int i = 0; i < 2; i++) begin
      chk("drain_ready", 32'(dif.op_ready), 0);
      chk("drain_valid", 32'(dif.sum_valid), 0);
      tick();
    end
    wait_result();
    chk("b2b_sum", 32'(dif.sum), 76);
    chk("done_ready", 32'(dif.op_ready), 0);
    handoff(5);

    // gapped terms with live operands on idle cycles
    for (int k = 0; k < 4; k++) begin
      issue_term(3'd7, 3'd7);
      for (int g = 0; g < 2; g++) begin
        dif.op_valid = 1'b0;
        a0 = 3'd7;
        b0 = 3'd7;
        tick();
      end
    end
    wait_result();
    chk("gap_sum", 32'(dif.sum), 196);
    chk("gap_ovf", 32'(dif.overflow), 0);
    handoff(0);

    // abort in DRAIN with products still in flight
    for (int k = 0; k < 4; k++) issue_term(3'd7, 3'd7);
    chk("abort_in_drain", 32'(dif.op_ready), 0);
    dif.clear = 1'b1;
    dif.op_valid = 1'b1;
    tick();
    dif.clear = 1'b0;
    dif.op_valid = 1'b0;
    exp_total = 0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_sum", 32'(dif.sum), 0);
      chk("abort_valid", 32'(dif.sum_valid), 0);
      chk("abort_cnt", 32'(dif.term_cnt), 0);
      chk("abort_ready", 32'(dif.op_ready), 1);
      tick();
    end
    for (int k = 0; k < 4; k++) issue_term(3'd1, 3'd1);
    wait_result();
    chk("abort_next_sum", 32'(dif.sum), 4);
    handoff(1);

    for (int r = 0; r < 6; r++) random_dot();

    // narrow accumulator: 49+49 wraps to 34
    for (int k = 0; k < 2; k++) begin
      chk("ovf_ready", 32'(oif.op_ready), 1);
      oif.op_valid = 1'b1;
      a1 = 3'd7;
      b1 = 3'd7;
      tick();
    end
    oif.op_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (oif.sum_valid === 1'b1) seen = 1'b1;
      else tick();
    end
    chk("ovf_valid_seen", 32'(seen), 1);
    chk("ovf_sum", 32'(oif.sum), 98 % 64);
    chk("ovf_flag", 32'(oif.overflow), 1);
    chk("ovf_cnt", 32'(oif.term_cnt), 2);
    oif.sum_ready = 1'b1;
    tick();
    oif.sum_ready = 1'b0;
    chk("ovf_cleared", 32'(oif.overflow), 0);
    chk("ovf_sum_cleared", 32'(oif.sum), 0);
    chk("ovf_valid_after", 32'(oif.sum_valid), 0);

    // reset mid-ISSUE
    issue_term(3'd3, 3'd5);
    issue_term(3'd7, 3'd7);
    issue_term(3'd2, 3'd6);
    chk("pre_rst_sum", 32'(dif.sum), 15);
    chk("pre_rst_cnt", 32'(dif.term_cnt), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(dif.op_ready), 0);
    chk("mid_rst_sum", 32'(dif.sum), 0);
    chk("mid_rst_valid", 32'(dif.sum_valid), 0);
    chk("mid_rst_cnt", 32'(dif.term_cnt), 0);
    chk("mid_rst_ovf", 32'(dif.overflow), 0);
    tick();
    tick();
    rst = 1'b0;
    exp_total = 0;
    tick();
    chk("post_rst_ready", 32'(dif.op_ready), 1);
    chk("post_rst_cnt", 32'(dif.term_cnt), 0);
    chk("post_rst_sum", 32'(dif.sum), 0);
    random_dot();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
